// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: architectural width, reset vector, queue slot states.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

  function automatic logic slot_busy(input slot_state_e s);
    return s != SLOT_EMPTY;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of in-flight fetches: slots are allocated at the tail on grant,
// filled in request order as responses return, and popped from the head.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [XLEN-1:0] i_fill_data,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic            o_head_filled,
  output logic [XLEN-1:0] o_head_pc,
  output logic [XLEN-1:0] o_head_data,
  output logic [CW-1:0]   o_used_cnt,
  output logic [CW-1:0]   o_pending_cnt
);

  slot_state_e     state_q [DEPTH];
  slot_state_e     state_d [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc_d    [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [XLEN-1:0] data_d  [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   fill_q, fill_d;

  // Responses return in order, so a separate fill pointer always names the oldest PENDING slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = SLOT_EMPTY;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
    end else begin
      if (i_pop) begin
        state_d[head_q] = SLOT_EMPTY;
        head_d          = head_q + PW'(1);
      end
      if (i_fill) begin
        state_d[fill_q] = SLOT_FILLED;
        data_d[fill_q]  = i_fill_data;
        fill_d          = fill_q + PW'(1);
      end
      if (i_alloc) begin
        state_d[tail_q] = SLOT_PENDING;
        pc_d[tail_q]    = i_alloc_pc;
        tail_d          = tail_q + PW'(1);
      end
    end
  end

  always_comb begin
    o_used_cnt    = '0;
    o_pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_used_cnt    = o_used_cnt + CW'(slot_busy(state_q[i]));
      o_pending_cnt = o_pending_cnt + CW'(state_q[i] == SLOT_PENDING);
    end
    o_head_filled = state_q[head_q] == SLOT_FILLED;
    o_head_pc     = pc_q[head_q];
    o_head_data   = data_q[head_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= SLOT_EMPTY;
        pc_q[i]    <= '0;
        data_q[i]  <= INST_NOP;
      end
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        pc_q[i]    <= pc_d[i];
        data_q[i]  <= data_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC, request throttling and stale-response dropping
// around a fetch_queue that buffers instructions for the decoder.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_dec_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            run_q, run_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   used_cnt;
  logic [CW-1:0]   pending_cnt;
  logic            head_filled;
  logic            grant;
  logic            pop;
  logic            fill;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_alloc       (grant),
    .i_alloc_pc    (pc_q),
    .i_fill        (fill),
    .i_fill_data   (i_imem_rdata),
    .i_pop         (pop),
    .i_flush       (i_redirect),
    .o_head_filled (head_filled),
    .o_head_pc     (o_inst_pc),
    .o_head_data   (o_inst_data),
    .o_used_cnt    (used_cnt),
    .o_pending_cnt (pending_cnt)
  );

  // Responses still owed for flushed requests count against capacity until they drain.
  always_comb begin
    o_imem_req   = run_q & ~i_redirect & ((SW'(used_cnt) + SW'(drop_q)) < SW'(DEPTH));
    grant        = o_imem_req & i_imem_gnt;
    o_inst_valid = head_filled & ~i_redirect;
    pop          = o_inst_valid & i_dec_ready;
    fill         = i_imem_rvalid & (drop_q == '0) & ~i_redirect;
    run_d        = 1'b1;
    pc_d         = pc_q;
    drop_d       = drop_q;
    if (i_redirect) begin
      pc_d   = i_redirect_pc & ~XLEN'(3);
      drop_d = drop_q + pending_cnt - CW'(i_imem_rvalid);
    end else begin
      if (grant) pc_d = pc_q + XLEN'(4);
      if (i_imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  assign o_imem_addr = pc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= run_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a transaction-level model of the fetch stream and an in-order
// memory with epoch-tagged requests, checked against the DUT every cycle.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic        i_dec_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst_data   (o_inst_data),
    .o_inst_pc     (o_inst_pc),
    .i_dec_ready   (i_dec_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] pc; bit filled; } fq_ent_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } mem_ent_t;

  fq_ent_t     fq[$];
  mem_ent_t    mem_q[$];
  logic [31:0] pops[$];
  logic [31:0] pc_m;
  logic [31:0] exp_next;
  bit          run_m;
  int          epoch;
  int          cyc;
  int          mem_lat;
  int          n_checks;
  int          n_fail;
  int          dut_grants;
  bit          cap_en;
  logic [31:0] cap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model, cross the edge.
  task automatic apply_stimulus(input logic ready, input logic gnt, input logic redir,
                                input logic [31:0] rpc);
    logic     rv;
    logic     exp_req;
    logic     exp_valid;
    int       stale;
    bit       done;
    mem_ent_t m;
    fq_ent_t  f;
    rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    i_dec_ready   = ready;
    i_imem_gnt    = gnt;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    stale = 0;
    foreach (mem_q[k]) if (mem_q[k].epoch != epoch) stale++;
    exp_req   = run_m && !redir && ((fq.size() + stale) < DEPTH);
    exp_valid = !redir && (fq.size() > 0) && fq[0].filled;
    check_output("imem_req", 32'(o_imem_req), 32'(exp_req));
    if (exp_req) check_output("imem_addr", o_imem_addr, pc_m);
    check_output("inst_valid", 32'(o_inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_output("inst_pc", o_inst_pc, fq[0].pc);
      check_output("inst_data", o_inst_data, mem_word(fq[0].pc));
    end
    check_output("drop_cnt", 32'(dut.drop_q), 32'(stale));
    if (o_imem_req && gnt) dut_grants++;
    if (cap_en && o_imem_req) begin
      cap_addr = o_imem_addr;
      cap_en   = 1'b0;
    end
    if (rv) begin
      m = mem_q.pop_front();
      if (m.epoch == epoch) begin
        done = 1'b0;
        foreach (fq[k]) if (!done && !fq[k].filled) begin
          fq[k].filled = 1'b1;
          done = 1'b1;
        end
      end
    end
    if (redir) begin
      fq.delete();
      epoch++;
      pc_m     = rpc & ~32'h3;
      exp_next = pc_m;
    end else begin
      if (exp_valid && ready) begin
        void'(fq.pop_front());
        check_output("consume_seq", o_inst_pc, exp_next);
        pops.push_back(o_inst_pc);
        exp_next = exp_next + 32'd4;
      end
      if (exp_req && gnt) begin
        f.pc = pc_m; f.filled = 1'b0;
        fq.push_back(f);
        m.addr = pc_m; m.epoch = epoch; m.due = cyc + mem_lat;
        mem_q.push_back(m);
        pc_m = pc_m + 32'd4;
      end
    end
    run_m = 1'b1;
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n       = 1'b0;
    i_dec_ready   = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    #1;
    check_output("rst_imem_req", 32'(o_imem_req), 32'd0);
    check_output("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    check_output("rst_imem_addr", o_imem_addr, RESET_PC);
    fq.delete();
    mem_q.delete();
    pc_m     = RESET_PC;
    exp_next = RESET_PC;
    run_m    = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; mem_lat = 1;
    dut_grants = 0; cap_en = 1'b0; cap_addr = 32'hDEAD_BEEF;
    i_rst_n = 1'b1;
    #2;
    do_reset();

    // Streaming with single-cycle memory and an always-ready decoder.
    mem_lat = 1;
    pops.delete();
    repeat (20) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("stream_pop_count", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      check_output("stream_pc0", pops[0], 32'h0);
      check_output("stream_pc1", pops[1], 32'h4);
      check_output("stream_pc2", pops[2], 32'h8);
    end

    // Decoder stall: at most DEPTH grants while blocked, then release.
    do_reset();
    repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    dut_grants = 0;
    repeat (5) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("stall_grants_le_depth", 32'(dut_grants <= DEPTH), 32'd1);
    repeat (10) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Redirect with two requests outstanding on a 3-cycle memory.
    do_reset();
    mem_lat = 3;
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    pops.delete();
    cap_en = 1'b1; cap_addr = 32'hDEAD_BEEF;
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    check_output("redirect_drop_cnt", 32'(dut.drop_q), 32'd2);
    repeat (15) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("redirect_first_addr", cap_addr, 32'h100);
    check_output("redirect_first_pc", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h100);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    mem_lat = 1;
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    pops.delete();
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check_output("coincide_drop_cnt", 32'(dut.drop_q), 32'd0);
    repeat (10) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("coincide_first_pc", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    pops.delete();
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    repeat (12) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("wrap_pop_count", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      check_output("wrap_pc0", pops[0], 32'hFFFF_FFF8);
      check_output("wrap_pc1", pops[1], 32'hFFFF_FFFC);
      check_output("wrap_pc2", pops[2], 32'h0000_0000);
    end

    // Asynchronous reset mid-fetch, then restart from the reset vector.
    do_reset();
    for (int i = 0; i < 100 && pc_m != 32'h40; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("midreset_pc40", o_imem_addr, 32'h40);
    #2;
    do_reset();
    cap_en = 1'b1; cap_addr = 32'hDEAD_BEEF;
    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("midreset_restart_addr", cap_addr, RESET_PC);

    // Randomized traffic: 3-cycle then 1-cycle memory, random ready/grant/redirect.
    mem_lat = 3;
    for (int i = 0; i < 1500; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 19) == 0), $urandom);
    mem_lat = 1;
    for (int i = 0; i < 1000; i++)
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 29) == 0), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
